data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//  Shared data memory for the NRISC multi-core cluster: 2^Lmem words of TAM bits.
//  Two independent core ports, one per core, each with write and load strobes.
//  Synchronous writes, registered reads with 1-cycle latency.
//  Sits between the core load/store units and the data address space.
// PARAMETERS
//  Ncores  2   number of core ports; this implementation supports exactly 2 (ports 0 and 1)
//  Lmem    8   address bits actually decoded; depth = 2^Lmem words (256)
//  TAM     16  data and address word width
// PORTS
//  clk        in   1          single clock; all state updates on posedge
//  rst        in   1          synchronous, active-high reset
//  dataIN0    in   [0:TAM-1]  write data, port 0
//  dataIN1    in   [0:TAM-1]  write data, port 1
//  dataADDR0  in   [0:TAM-1]  word address, port 0
//  dataADDR1  in   [0:TAM-1]  word address, port 1
//  dataWrite  in   [0:Ncores-1]  write strobe; bit 0 = port 0, bit 1 = port 1
//  dataLoad   in   [0:Ncores-1]  load strobe; bit 0 = port 0, bit 1 = port 1
//  dataOUT0   out  [0:TAM-1]  registered read data, port 0
//  dataOUT1   out  [0:TAM-1]  registered read data, port 1
// BEHAVIOUR
//  - Vectors are declared [0:N-1]: index 0 is the MSB. Strobe bit k controls port k.
//  - Addressing: only the Lmem LSBs of dataADDRk are decoded. Upper bits are ignored.
//    Example: 0x0100 aliases 0x0000, and 0x00FF+1 wraps to word 0.
//  - Reset (rst=1 at posedge):
//    - all 2^Lmem words cleared to 0
//    - dataOUT0 = dataOUT1 = 0
//    - writes and loads in that cycle are ignored
//  - Write: at posedge with dataWrite[k]=1, mem[ADDRk] <= dataINk.
//  - Dual write to the same address in the same cycle: port 0 wins; port 1's write is dropped.
//  - Load: at posedge with dataLoad[k]=1, dataOUTk <= mem[ADDRk].
//    The value is visible one cycle after the strobe (latency 1).
//  - dataLoad[k]=0: dataOUTk holds its previous value.
//  - Read-during-write is write-first, on the same or the other port.
//    A load of an address being written in the same cycle returns the new data.
//    If both ports write that address, the returned data is port 0's.
//  - Write and load on the same port in one cycle: both happen; dataOUTk = dataINk.
//  - Write and load strobes are independent. There is no handshake, stall or error output.
//  - No other state exists. There is no FSM; the memory array and two output registers are the only storage.
// TESTING
//  1. Reset: preload words, hold rst=1 one cycle.
//     -> dataOUT0/1=0; later loads from addresses 0..255 all return 0.
//  2. Write then read: ADDR0=0x0000, IN0=0x0001, ADDR1=0x0001, IN1=0x0002; write=2'b11 one cycle, then load=2'b11.
//     -> next cycle OUT0=0x0001, OUT1=0x0002.
//  3. Address sweep: 256 iterations, incrementing both addresses, unique data per address, write then load.
//     -> every readback matches.
//     -> stepping the address and reloading shows no stale or duplicated word, i.e. writes do not hit the whole array.
//  4. Collision: both ports write 0x0010, IN0=0xAAAA, IN1=0x5555.
//     -> a later load from either port returns 0xAAAA.
//  5. Write-first and hold:
//     - port 0 writes 0x1234 to 0x20 while port 1 loads 0x20 -> OUT1=0x1234 next cycle
//     - then load=0 -> OUT0/OUT1 hold their values
//  6. Wrap/alias: write 0xBEEF to 0x0105, load 0x0005 -> 0xBEEF.

Source files
------------

// File: rtl/data_mem.sv
// Shared two-port data memory for the NRISC cluster: synchronous writes,
// registered write-first reads, port 0 wins same-address write collisions.
module data_mem #(
  parameter int Ncores = 2,
  parameter int Lmem   = 8,
  parameter int TAM    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:TAM-1]    dataIN0,
  input  logic [0:TAM-1]    dataIN1,
  input  logic [0:TAM-1]    dataADDR0,
  input  logic [0:TAM-1]    dataADDR1,
  input  logic [0:Ncores-1] dataWrite,
  input  logic [0:Ncores-1] dataLoad,
  output logic [0:TAM-1]    dataOUT0,
  output logic [0:TAM-1]    dataOUT1
);

  localparam int DEPTH = 1 << Lmem;

  logic [0:TAM-1]  mem_q [DEPTH];
  logic [0:TAM-1]  out0_q, out1_q;
  logic [0:TAM-1]  out0_d, out1_d;
  logic [Lmem-1:0] addr0, addr1;
  logic            we0, we1, we1_eff, ld0, ld1;

  // Vectors are [0:N-1], so the decoded LSBs sit at the high indices.
  assign addr0 = dataADDR0[TAM-Lmem:TAM-1];
  assign addr1 = dataADDR1[TAM-Lmem:TAM-1];
  assign we0   = dataWrite[0];
  assign we1   = dataWrite[1];
  assign ld0   = dataLoad[0];
  assign ld1   = dataLoad[1];

  // Port 1's write is dropped when port 0 targets the same word.
  assign we1_eff = we1 && !(we0 && (addr0 == addr1));

  // Write-first bypass: a load sees any write landing on its word this cycle,
  // with port 0's data taking precedence.
  always_comb begin
    out0_d = mem_q[addr0];
    out1_d = mem_q[addr1];
    if (we0) begin
      out0_d = dataIN0;
    end else if (we1 && (addr1 == addr0)) begin
      out0_d = dataIN1;
    end
    if (we0 && (addr0 == addr1)) begin
      out1_d = dataIN0;
    end else if (we1) begin
      out1_d = dataIN1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      out0_q <= '0;
      out1_q <= '0;
    end else begin
      if (we1_eff) begin
        mem_q[addr1] <= dataIN1;
      end
      if (we0) begin
        mem_q[addr0] <= dataIN0;
      end
      if (ld0) begin
        out0_q <= out0_d;
      end
      if (ld1) begin
        out1_q <= out1_d;
      end
    end
  end

  assign dataOUT0 = out0_q;
  assign dataOUT1 = out1_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed vector table, address sweeps,
// and randomized traffic against a word-array reference model.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [0:15] dataIN0 = '0, dataIN1 = '0, dataADDR0 = '0, dataADDR1 = '0;
  logic [0:1]  dataWrite = '0, dataLoad = '0;
  logic [0:15] dataOUT0, dataOUT1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mdl [256];
  logic [15:0] exp0, exp1;

  typedef struct {
    logic        rst;
    logic [1:0]  wr;   // {port0, port1}
    logic [1:0]  ld;   // {port0, port1}
    logic [15:0] a0, a1, d0, d1, e0, e1;
  } vec_t;

  vec_t tbl [17];

  data_mem #(.Ncores(2), .Lmem(8), .TAM(16)) dut (
    .clk(clk), .rst(rst),
    .dataIN0(dataIN0), .dataIN1(dataIN1),
    .dataADDR0(dataADDR0), .dataADDR1(dataADDR1),
    .dataWrite(dataWrite), .dataLoad(dataLoad),
    .dataOUT0(dataOUT0), .dataOUT1(dataOUT1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // One clock of stimulus; the model is a plain word array: writes land
  // (port 0 last so it wins), then loads read the updated array.
  task automatic step(input logic r, input logic [1:0] wr, input logic [1:0] ld,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1);
    rst = r; dataWrite = wr; dataLoad = ld;
    dataADDR0 = a0; dataADDR1 = a1; dataIN0 = d0; dataIN1 = d1;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 256; i++) mdl[i] = '0;
      exp0 = '0; exp1 = '0;
    end else begin
      if (wr[0]) mdl[a1 % 256] = d1;
      if (wr[1]) mdl[a0 % 256] = d0;
      if (ld[1]) exp0 = mdl[a0 % 256];
      if (ld[0]) exp1 = mdl[a1 % 256];
    end
  endtask

  function automatic logic [15:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b ^ 8'h3C, ~b};
  endfunction

  initial begin
    tbl[0]  = '{1'b0, 2'b11, 2'b00, 16'h0010, 16'h0011, 16'h1111, 16'h2222, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 2'b00, 2'b11, 16'h0010, 16'h0011, 16'h0000, 16'h0000, 16'h1111, 16'h2222};
    tbl[2]  = '{1'b1, 2'b11, 2'b11, 16'h0010, 16'h0011, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b0, 2'b00, 2'b11, 16'h0010, 16'h0011, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b0, 2'b11, 2'b00, 16'h0000, 16'h0001, 16'h0001, 16'h0002, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b0, 2'b00, 2'b11, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0002};
    tbl[6]  = '{1'b0, 2'b11, 2'b00, 16'h0010, 16'h0010, 16'hAAAA, 16'h5555, 16'h0001, 16'h0002};
    tbl[7]  = '{1'b0, 2'b00, 2'b11, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 16'hAAAA, 16'hAAAA};
    tbl[8]  = '{1'b0, 2'b10, 2'b01, 16'h0020, 16'h0020, 16'h1234, 16'h0000, 16'hAAAA, 16'h1234};
    tbl[9]  = '{1'b0, 2'b00, 2'b00, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 16'hAAAA, 16'h1234};
    tbl[10] = '{1'b0, 2'b10, 2'b00, 16'h0105, 16'h0000, 16'hBEEF, 16'h0000, 16'hAAAA, 16'h1234};
    tbl[11] = '{1'b0, 2'b00, 2'b10, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h1234};
    tbl[12] = '{1'b0, 2'b01, 2'b01, 16'h0000, 16'h0030, 16'h0000, 16'h7777, 16'hBEEF, 16'h7777};
    tbl[13] = '{1'b0, 2'b11, 2'b11, 16'h0040, 16'h0040, 16'h1357, 16'h2468, 16'h1357, 16'h1357};
    tbl[14] = '{1'b0, 2'b01, 2'b10, 16'h0041, 16'h0041, 16'h0000, 16'h9999, 16'h9999, 16'h1357};
    tbl[15] = '{1'b0, 2'b00, 2'b01, 16'h0000, 16'hFF40, 16'h0000, 16'h0000, 16'h9999, 16'h1357};
    tbl[16] = '{1'b0, 2'b00, 2'b01, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h9999, 16'h0001};

    // Initial reset: both outputs must come up zero.
    step(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("reset_out0", dataOUT0, 16'h0000);
    chk("reset_out1", dataOUT1, 16'h0000);

    // Directed vectors with hand-computed expectations.
    for (int v = 0; v < 17; v++) begin
      step(tbl[v].rst, tbl[v].wr, tbl[v].ld, tbl[v].a0, tbl[v].a1, tbl[v].d0, tbl[v].d1);
      chk($sformatf("vec%0d_out0", v), dataOUT0, tbl[v].e0);
      chk($sformatf("vec%0d_out1", v), dataOUT1, tbl[v].e1);
      $display("vec %0d: wr=%b ld=%b a0=%h a1=%h out0=%h out1=%h", v, tbl[v].wr, tbl[v].ld,
               tbl[v].a0, tbl[v].a1, dataOUT0, dataOUT1);
    end

    // Reset clears every word: sweep both ports over all addresses.
    step(1'b1, 2'b11, 2'b11, 16'h0010, 16'h0040, 16'h5A5A, 16'hA5A5);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 2'b00, 2'b11, 16'(i), 16'(255 - i), 16'h0, 16'h0);
      chk("clear_out0", dataOUT0, 16'h0000);
      chk("clear_out1", dataOUT1, 16'h0000);
    end
    $display("clear sweep: 256 addresses loaded on both ports");

    // Address sweep: unique data per word, then reload in a different order.
    for (int i = 0; i < 128; i++) begin
      step(1'b0, 2'b11, 2'b00, 16'(2 * i), 16'(2 * i + 1), pat(2 * i), pat(2 * i + 1));
    end
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 2'b00, 2'b11, 16'(i), 16'(255 - i), 16'h0, 16'h0);
      chk("sweep_out0", dataOUT0, pat(i));
      chk("sweep_out1", dataOUT1, pat(255 - i));
      chk("sweep_model0", dataOUT0, exp0);
    end
    $display("address sweep: 256 words written and read back");

    // Randomized traffic on a narrow address window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a0, a1;
      logic        r;
      a0 = {8'($urandom), 8'($urandom_range(0, 15))};
      a1 = {8'($urandom), 8'($urandom_range(0, 15))};
      r  = ($urandom_range(0, 199) == 0);
      step(r, 2'($urandom), 2'($urandom), a0, a1, 16'($urandom), 16'($urandom));
      chk("rand_out0", dataOUT0, exp0);
      chk("rand_out1", dataOUT1, exp1);
    end
    $display("random phase: 3000 cycles compared against reference model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
